intersection_ctrl: RTL and testbench



---
 rtl/intersection_ctrl.sv | 148 ++++++++++++++
 tb/tb_intersection_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer: NS rests on green, EW and an exclusive pedestrian
// phase are served on request, with amber and all-red clearance between roads.
module intersection_ctrl #(
    parameter int unsigned NS_GREEN_TICS = 20,
    parameter int unsigned EW_GREEN_TICS = 10,
    parameter int unsigned AMBER_TICS    = 4,
    parameter int unsigned ALLRED_TICS   = 2,
    parameter int unsigned WALK_TICS     = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_amber,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_amber,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        StAllredNs = 3'd0,
        StNsGreen  = 3'd1,
        StNsAmber  = 3'd2,
        StAllredEw = 3'd3,
        StWalk     = 3'd4,
        StEwGreen  = 3'd5,
        StEwAmber  = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] NsGreenLd = CNT_W'(NS_GREEN_TICS - 1);
    localparam logic [CNT_W-1:0] EwGreenLd = CNT_W'(EW_GREEN_TICS - 1);
    localparam logic [CNT_W-1:0] AmberLd   = CNT_W'(AMBER_TICS - 1);
    localparam logic [CNT_W-1:0] AllredLd  = CNT_W'(ALLRED_TICS - 1);
    localparam logic [CNT_W-1:0] WalkLd    = CNT_W'(WALK_TICS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;

    logic             side_any;
    logic             ped_any;
    logic             state_legal;

    function automatic logic [CNT_W-1:0] load_for(input state_e st);
        case (st)
            StNsGreen:            load_for = NsGreenLd;
            StNsAmber, StEwAmber: load_for = AmberLd;
            StWalk:               load_for = WalkLd;
            StEwGreen:            load_for = EwGreenLd;
            default:              load_for = AllredLd;
        endcase
    endfunction

    // A request on the deciding edge counts, so a resting NS green leaves on that edge.
    assign side_any    = side_pend_q | side_req;
    assign ped_any     = ped_pend_q | ped_req;
    assign state_legal = (3'(state_q) != 3'd7);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!state_legal) begin
            state_d = StAllredNs;
            cnt_d   = AllredLd;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            case (state_q)
                StAllredNs: state_d = StNsGreen;
                StNsGreen:  if (side_any || ped_any) state_d = StNsAmber;
                StNsAmber:  state_d = StAllredEw;
                StAllredEw: state_d = ped_any ? StWalk : StEwGreen;
                StWalk:     state_d = side_any ? StEwGreen : StAllredNs;
                StEwGreen:  state_d = StEwAmber;
                StEwAmber:  state_d = StAllredNs;
                default:    state_d = StAllredNs;
            endcase
            // Resting NS green keeps the counter parked at zero.
            if (state_d != state_q) begin
                cnt_d = load_for(state_d);
            end
        end
    end

    // Entering the serving phase clears its latch, winning over a coincident request.
    always_comb begin
        side_pend_d = side_any;
        ped_pend_d  = ped_any;
        if (state_d == StEwGreen && state_q != StEwGreen) begin
            side_pend_d = 1'b0;
        end
        if (state_d == StWalk && state_q != StWalk) begin
            ped_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAllredNs;
            cnt_q       <= AllredLd;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
        end
    end

    always_comb begin
        ns_red   = 1'b1;
        ns_amber = 1'b0;
        ns_green = 1'b0;
        ew_red   = 1'b1;
        ew_amber = 1'b0;
        ew_green = 1'b0;
        walk     = 1'b0;
        phase    = 3'(state_q);
        case (state_q)
            StNsGreen: begin
                ns_red   = 1'b0;
                ns_green = 1'b1;
            end
            StNsAmber: begin
                ns_red   = 1'b0;
                ns_amber = 1'b1;
            end
            StWalk: walk = 1'b1;
            StEwGreen: begin
                ew_red   = 1'b0;
                ew_green = 1'b1;
            end
            StEwAmber: begin
                ew_red   = 1'b0;
                ew_amber = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: phase-run vector table, async-reset sequence, and
// random requests checked against a duration-table reference model.
module tb_intersection_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       ns_red, ns_amber, ns_green;
    logic       ew_red, ew_amber, ew_green;
    logic       walk;
    logic [2:0] phase;
    logic [9:0] obs;

    always #5 clk = ~clk;

    intersection_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .side_req (side_req),
        .ped_req  (ped_req),
        .ns_red   (ns_red),
        .ns_amber (ns_amber),
        .ns_green (ns_green),
        .ew_red   (ew_red),
        .ew_amber (ew_amber),
        .ew_green (ew_green),
        .walk     (walk),
        .phase    (phase)
    );

    assign obs = {phase, ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk};

    // Lamps per phase: {ns_r, ns_a, ns_g, ew_r, ew_a, ew_g, walk}
    logic [6:0] lamp_tab [7] = '{7'b1001000, 7'b0011000, 7'b0101000, 7'b1001000,
                                 7'b1001001, 7'b1000010, 7'b1000100};
    int         dur [7] = '{2, 20, 4, 2, 8, 10, 4};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: phase, cycles spent in it, and outstanding requests.
    int m_ph, m_el;
    bit m_side, m_ped;

    function automatic void model_reset();
        m_ph = 0; m_el = 0; m_side = 1'b0; m_ped = 1'b0;
    endfunction

    function automatic void model_step(input bit s, input bit p);
        bit se, pe;
        int nxt;
        se  = m_side | s;
        pe  = m_ped | p;
        nxt = m_ph;
        if (m_el + 1 < dur[m_ph]) begin
            m_el++;
        end else begin
            case (m_ph)
                0: nxt = 1;
                1: nxt = (se || pe) ? 2 : 1;
                2: nxt = 3;
                3: nxt = pe ? 4 : 5;
                4: nxt = se ? 5 : 0;
                5: nxt = 6;
                default: nxt = 0;
            endcase
            if (nxt != m_ph) m_el = 0;
        end
        m_side = (nxt == 5 && m_ph != 5) ? 1'b0 : se;
        m_ped  = (nxt == 4 && m_ph != 4) ? 1'b0 : pe;
        m_ph   = nxt;
    endfunction

    function automatic int expect_vec(input int ph);
        return int'({3'(ph), lamp_tab[ph]});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit s, input bit p);
        side_req = s;
        ped_req  = p;
        @(posedge clk);
        model_step(s, p);
        #1;
        check("model", int'(obs), expect_vec(m_ph));
        check("excl", int'((ns_green | ns_amber) & (ew_green | ew_amber)), 0);
        check("ns_onehot", int'(ns_red) + int'(ns_amber) + int'(ns_green), 1);
        check("ew_onehot", int'(ew_red) + int'(ew_amber) + int'(ew_green), 1);
    endtask

    task automatic do_reset();
        side_req = 1'b0;
        ped_req  = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        check("reset_async", int'(obs), int'({3'd0, 7'b1001000}));
        @(posedge clk);
        #1;
        check("reset_hold", int'(obs), int'({3'd0, 7'b1001000}));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        bit         side;
        bit         ped;
        int         len;
        logic [2:0] ph;
    } seg_t;

    seg_t segs[$];

    function automatic void add(input bit r, input bit s, input bit p, input int len,
                                input logic [2:0] ph);
        seg_t e;
        e.rst = r; e.side = s; e.ped = p; e.len = len; e.ph = ph;
        segs.push_back(e);
    endfunction

    initial begin
        // Idle after reset: 1 more all-red cycle, then rest on NS green.
        add(1, 0, 0, 1, 0);   add(0, 0, 0, 200, 1);
        // Side pulse at NS green cycle 5: full 20-cycle minimum, then EW round.
        add(1, 0, 0, 1, 0);   add(0, 0, 0, 5, 1);   add(0, 1, 0, 15, 1);
        add(0, 0, 0, 4, 2);   add(0, 0, 0, 2, 3);   add(0, 0, 0, 10, 5);
        add(0, 0, 0, 4, 6);   add(0, 0, 0, 2, 0);   add(0, 0, 0, 30, 1);
        // Side request while resting leaves immediately.
        add(0, 1, 0, 4, 2);   add(0, 0, 0, 2, 3);   add(0, 0, 0, 10, 5);
        add(0, 0, 0, 4, 6);   add(0, 0, 0, 2, 0);   add(0, 0, 0, 25, 1);
        // Pedestrian only.
        add(0, 0, 1, 4, 2);   add(0, 0, 0, 2, 3);   add(0, 0, 0, 8, 4);
        add(0, 0, 0, 2, 0);   add(0, 0, 0, 25, 1);
        // Both at once, plus a second side request during EW green.
        add(0, 1, 1, 4, 2);   add(0, 0, 0, 2, 3);   add(0, 0, 0, 8, 4);
        add(0, 0, 0, 3, 5);   add(0, 1, 0, 7, 5);   add(0, 0, 0, 4, 6);
        add(0, 0, 0, 2, 0);   add(0, 0, 0, 20, 1);  add(0, 0, 0, 4, 2);
        add(0, 0, 0, 2, 3);   add(0, 0, 0, 10, 5);  add(0, 0, 0, 4, 6);
        add(0, 0, 0, 2, 0);   add(0, 0, 0, 25, 1);
        // Lead-in to the mid-EW reset sequence.
        add(0, 1, 0, 4, 2);   add(0, 0, 0, 2, 3);   add(0, 0, 0, 3, 5);

        #2;
        for (int i = 0; i < segs.size(); i++) begin
            if (segs[i].rst) do_reset();
            for (int c = 0; c < segs[i].len; c++) begin
                if (c == 0) cycle(segs[i].side, segs[i].ped);
                else cycle(1'b0, 1'b0);
                check($sformatf("seg%0d", i), int'(obs),
                      int'({segs[i].ph, lamp_tab[segs[i].ph]}));
            end
        end

        // Pending pedestrian request in EW green is discarded by a mid-phase reset.
        cycle(1'b0, 1'b1);
        check("ped_in_ew_phase", int'(phase), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_lamps", int'(obs), int'({3'd0, 7'b1001000}));
        model_reset();
        @(posedge clk);
        #1;
        check("midop_reset_hold", int'(obs), int'({3'd0, 7'b1001000}));
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0);
        check("post_reset_allred", int'(phase), 0);
        for (int c = 0; c < 30; c++) begin
            cycle(1'b0, 1'b0);
            check("post_reset_rest", int'(obs), int'({3'd1, 7'b0011000}));
        end

        // Random requests, occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            cycle(bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 29) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
